// File: rtl/elastic_accum.sv
`default_nettype none
// ============================================================================
// Module   : elastic_accum
// Brief    : Sums groups of up to N input beats (closed early by t_last) and
//            emits one registered sum beat per group with its beat count.
//            Valid/ready backpressure on both the input and output sides.
// Revision : 1.0 - initial release
// ============================================================================
module elastic_accum #(
  parameter  int DW = 32,
  parameter  int N  = 4,
  localparam int SW = DW + $clog2(N),
  localparam int CW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rstf,
  input  logic [DW-1:0] t_data,
  input  logic          t_valid,
  input  logic          t_last,
  output logic          t_ready,
  output logic [SW-1:0] i_data,
  output logic [CW-1:0] i_cnt,
  output logic          i_valid,
  input  logic          i_ready
);

  localparam logic [CW-1:0] C_LAST_IDX = CW'(N - 1);

  logic [SW-1:0] r_acc;
  logic [CW-1:0] r_cnt;

  logic          w_close_cand;
  logic          w_accept;
  logic          w_close;
  logic          w_xfer;
  logic [SW-1:0] w_sum;
  logic [CW-1:0] w_cnt_inc;

  // Ready and sum datapath: only a group-closing beat needs the output
  // register to be free, partial beats always fold into the accumulator.
  always_comb begin
    w_close_cand = (r_cnt == C_LAST_IDX) | t_last;
    t_ready      = rstf & (~w_close_cand | ~i_valid | i_ready);
    w_accept     = t_valid & t_ready;
    w_close      = w_accept & w_close_cand;
    w_xfer       = i_valid & i_ready;
    w_sum        = r_acc + SW'(t_data);
    w_cnt_inc    = r_cnt + CW'(1);
  end

  // Accumulator, beat counter and output register (i_valid is the
  // EMPTY/FULL state of the output slot).
  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      i_data  <= '0;
      i_cnt   <= '0;
      i_valid <= 1'b0;
    end else begin
      if (w_close) begin
        i_data  <= w_sum;
        i_cnt   <= w_cnt_inc;
        i_valid <= 1'b1;
        r_acc   <= '0;
        r_cnt   <= '0;
      end else begin
        if (w_accept) begin
          r_acc <= w_sum;
          r_cnt <= w_cnt_inc;
        end
        // Data and count stay stale after a transfer; only valid drops.
        if (w_xfer) begin
          i_valid <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/elastic_accum.md
Name: elastic_accum

Overview:
- Downstream consumer of the registered valid/ready elastic stage. It takes a stream of DW-bit beats and sums groups of N beats, or fewer when t_last closes a group early.
- It emits one registered sum beat per group, together with the number of beats in that group.
- Full valid/ready backpressure on both sides.
- Sits between the elastic data path and the result collector in the testbench top.

Parameters:
DW, 32, input beat width
N, 4, maximum beats per group (N >= 2)
SW, DW+$clog2(N), sum width (derived, do not override)
CW, $clog2(N)+1, beat-count width (derived)

Ports:
clk  input  1  clock, all state on posedge
rstf  input  1  asynchronous active-low reset
t_data  input  DW  input beat, unsigned
t_valid  input  1  input beat valid
t_last  input  1  closes the current group on this beat (ignored unless t_valid)
t_ready  output  1  block accepts the input beat this cycle
i_data  output  SW  group sum, unsigned
i_cnt  output  CW  number of beats in the emitted group, 1..N
i_valid  output  1  output beat valid
i_ready  input  1  downstream accepts the output beat

Behaviour:
- Clock and reset: one clock (clk); reset rstf is asynchronous, active-low.
- Reset values:
  - Outputs: i_data=0, i_cnt=0, i_valid=0.
  - Internal: acc=0, cnt=0.
  - t_ready is 0 combinationally whenever rstf=0.
- Acceptance: a beat is accepted when t_valid & t_ready. Output transfer occurs when i_valid & i_ready.
- Closing beat: an accepted beat "closes" a group when cnt==N-1 or t_last=1.
- t_ready = rstf & (~closing_candidate | ~i_valid | i_ready), where closing_candidate = (cnt==N-1) | t_last.
  - Non-closing beats are accepted even while an output beat is stalled.
  - Only the closing beat waits for the output register to free.
  - t_ready may depend combinationally on t_valid/t_last; the upstream must not make t_valid depend on t_ready.
- Accepted non-closing beat: acc <= acc + t_data; cnt <= cnt+1.
- Accepted closing beat:
  - i_data <= acc + t_data; i_cnt <= cnt+1; i_valid <= 1.
  - acc <= 0; cnt <= 0.
- Output transfer with no new closing beat in the same cycle: i_valid <= 0. i_data and i_cnt hold their stale values.
- Simultaneous output transfer and closing beat: the new result loads and i_valid stays 1. Full throughput is one group per cycle when N groups are closed by t_last every beat.
- Latency: the sum appears on i_data one cycle after the closing beat is accepted.
- While i_valid=1 and i_ready=0: i_data, i_cnt and i_valid hold stable.
- Width rules:
  - acc is SW bits; zero-extend t_data before adding.
  - N beats of max value never overflow SW.
  - i_cnt=N is encoded in CW bits.
- t_last on beat 0 gives a single-beat group: i_data=t_data, i_cnt=1.
- Reset asserted mid-group or with an output pending: partial acc/cnt are discarded and the pending output is dropped. After release the block starts at cnt=0 with i_valid=0.
- No state changes on cycles without an accepted beat or an output transfer.
- Expected RTL: a 2-state output register (EMPTY/FULL via i_valid), an accumulator, a beat counter and the ready logic; about 150 lines.

Test Plan:
- Basic group (DW=32, N=4, i_ready=1): beats 1,2,3,4 on consecutive cycles, t_last=0 -> one output i_data=10, i_cnt=4, i_valid high exactly 1 cycle, one cycle after beat 4.
- Early close: beats 5,7 with t_last on the 7; then beat 9 with t_last -> outputs (12,2) then (9,1).
- Overflow width: 4 beats of 32'hFFFF_FFFF -> i_data=34'h3_FFFF_FFFC, i_cnt=4.
- Backpressure:
  - Setup: i_ready=0 after the first group (1,1,1,1 -> sum 4).
  - Stimulus: send a second group 2,2,2,2.
  - Required: beats 2,2,2 are accepted; t_ready=0 on the 4th beat; the output holds 4 stable.
  - Release: raise i_ready -> 4 transfers; the same cycle accepts the closing beat; the next output is 8.
- Back-to-back t_last every beat, values 1..8, i_ready=1 -> eight outputs 1..8, each i_cnt=1, t_ready continuously 1, i_valid continuously 1.
- Reset mid-group: beats 3,3 accepted, then rstf low for 2 cycles -> i_valid=0 and t_ready=0 during reset. After release, beats 1,1,1,1 -> output 4, not 10.
